// File: rtl/hyperbus_reg_async_pkg.sv
// Shared types for the register-bus async source: FSM states, default bus structs, width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package hyperbus_reg_async_pkg;

    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefDataWidth = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ_HI,
        REQ_LO,
        RSP_WAIT,
        RSP_ACK,
        DONE
    } state_e;

    // Field order matches the packed wire order {addr, write, wdata, wstrb, valid}.
    typedef struct packed {
        logic [DefAddrWidth-1:0]   addr;
        logic                      write;
        logic [DefDataWidth-1:0]   wdata;
        logic [DefDataWidth/8-1:0] wstrb;
        logic                      valid;
    } reg_req_t;

    // Field order matches the packed wire order {rdata, error, ready}.
    typedef struct packed {
        logic [DefDataWidth-1:0] rdata;
        logic                    error;
        logic                    ready;
    } reg_rsp_t;

    function automatic int unsigned req_width(input int unsigned aw, input int unsigned dw);
        return aw + 1 + dw + dw / 8 + 1;
    endfunction

    function automatic int unsigned rsp_width(input int unsigned dw);
        return dw + 2;
    endfunction

    localparam int unsigned DefReqWidth = req_width(DefAddrWidth, DefDataWidth);
    localparam int unsigned DefRspWidth = rsp_width(DefDataWidth);

endpackage

// File: rtl/hyperbus_reg_async_src_if.sv
// Bundle of the register bus and both 4-phase async channels around the source.
// Latency: n/a (wires only).
// Backpressure: carried by the reg_rsp.ready pulse and the req/ack handshakes.
// Ports: master = source side (drives reg_rsp, req_req, req_data, rsp_ack);
//        slave  = requester/far-end side (drives reg_req, req_ack, rsp_req, rsp_data).
interface hyperbus_reg_async_src_if;
    import hyperbus_reg_async_pkg::*;

    reg_req_t                 reg_req;
    reg_rsp_t                 reg_rsp;
    logic                     req_req;
    logic                     req_ack;
    logic [DefReqWidth-1:0]   req_data;
    logic                     rsp_req;
    logic                     rsp_ack;
    logic [DefRspWidth-1:0]   rsp_data;

    modport master (
        input  reg_req, req_ack, rsp_req, rsp_data,
        output reg_rsp, req_req, req_data, rsp_ack
    );

    modport slave (
        output reg_req, req_ack, rsp_req, rsp_data,
        input  reg_rsp, req_req, req_data, rsp_ack
    );
endinterface

// File: rtl/hyperbus_reg_async_src_sync.sv
// Multi-flop synchronizer for one asynchronous handshake line.
// Latency: Stages cycles from d to q.
// Backpressure: none.
// Ports: clk, rst (sync active-high), d (async in), q (synchronized out).
module hyperbus_sync #(
    parameter int unsigned Stages = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [Stages-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[Stages-2:0], d};
        end
    end

    assign q = chain[Stages-1];
endmodule

// File: rtl/hyperbus_reg_async_src.sv
// Register-bus to 4-phase async bridge, source side: one transaction in flight at a time.
// Latency: at least 4*SyncStages+3 cycles from valid to the one-cycle ready pulse.
// Backpressure: requester holds valid until ready; a new request is only sampled in IDLE.
// Ports: clk_sys_i/rst_sys_i (sync active-high), reg_req_i/reg_rsp_o register bus,
//        async_reg_req_* request channel, async_reg_rsp_* response channel.
// Optional: HYPERBUS_REG_ASYNC_TIMEOUT_EN adds a response timeout of TimeoutCycles.
module hyperbus_reg_async_src #(
    parameter int unsigned RegAddrWidth  = 32,
    parameter int unsigned RegDataWidth  = 32,
    parameter int unsigned SyncStages    = 3,
    parameter int unsigned TimeoutCycles = 1024,
    parameter type reg_req_t = hyperbus_reg_async_pkg::reg_req_t,
    parameter type reg_rsp_t = hyperbus_reg_async_pkg::reg_rsp_t,
    localparam int unsigned RegReqWidth = hyperbus_reg_async_pkg::req_width(RegAddrWidth, RegDataWidth),
    localparam int unsigned RegRspWidth = hyperbus_reg_async_pkg::rsp_width(RegDataWidth)
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_sys_i,
    input  reg_req_t               reg_req_i,
    output reg_rsp_t               reg_rsp_o,
    output logic                   async_reg_req_req_o,
    input  logic                   async_reg_req_ack_i,
    output logic [RegReqWidth-1:0] async_reg_req_data_o,
    input  logic                   async_reg_rsp_req_i,
    output logic                   async_reg_rsp_ack_o,
    input  logic [RegRspWidth-1:0] async_reg_rsp_data_i
);
    import hyperbus_reg_async_pkg::*;

    state_e                  state_q, state_d;
    logic                    req_q, req_d;
    logic                    ack_q, ack_d;
    logic [RegReqWidth-1:0]  data_q, data_d;
    logic [RegDataWidth-1:0] rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    ack_s, rsp_s;
    logic                    rsp_ready;

    // The far end's own ready bit carries no information for us.
    logic unused_rsp_ready;
    assign unused_rsp_ready = async_reg_rsp_data_i[0];

    hyperbus_sync #(.Stages(SyncStages)) i_sync_ack (
        .clk (clk_sys_i),
        .rst (rst_sys_i),
        .d   (async_reg_req_ack_i),
        .q   (ack_s)
    );

    hyperbus_sync #(.Stages(SyncStages)) i_sync_rsp (
        .clk (clk_sys_i),
        .rst (rst_sys_i),
        .d   (async_reg_rsp_req_i),
        .q   (rsp_s)
    );

`ifdef HYPERBUS_REG_ASYNC_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    logic [CntW-1:0] cnt_q, cnt_d;
    // Remembers that the ready pulse was already given while DONE waits for the lines to drop.
    logic            sent_q;
`endif

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef HYPERBUS_REG_ASYNC_TIMEOUT_EN
            cnt_q   <= '0;
            sent_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef HYPERBUS_REG_ASYNC_TIMEOUT_EN
            cnt_q   <= cnt_d;
            sent_q  <= (state_q == DONE);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        ack_d   = ack_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef HYPERBUS_REG_ASYNC_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (reg_req_i.valid) begin
                    data_d  = {reg_req_i.addr, reg_req_i.write, reg_req_i.wdata,
                               reg_req_i.wstrb, reg_req_i.valid};
                    req_d   = 1'b1;
                    state_d = REQ_HI;
`ifdef HYPERBUS_REG_ASYNC_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                // data_q stays put until here so the far end can sample it at any point of the handshake.
                if (!ack_s) begin
                    state_d = RSP_WAIT;
                end
            end
            RSP_WAIT: begin
                if (rsp_s) begin
                    rdata_d = async_reg_rsp_data_i[RegRspWidth-1:2];
                    err_d   = async_reg_rsp_data_i[1];
                    ack_d   = 1'b1;
                    state_d = RSP_ACK;
                end
            end
            RSP_ACK: begin
                if (!rsp_s) begin
                    ack_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef HYPERBUS_REG_ASYNC_TIMEOUT_EN
                // After a timeout the far end may still be mid-handshake; wait for it to go quiet.
                if (!ack_s && !rsp_s) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef HYPERBUS_REG_ASYNC_TIMEOUT_EN
        if (state_q == REQ_HI || state_q == REQ_LO || state_q == RSP_WAIT) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                req_d   = 1'b0;
                ack_d   = 1'b0;
                rdata_d = '0;
                err_d   = 1'b1;
                state_d = DONE;
            end
        end
`endif
    end

`ifdef HYPERBUS_REG_ASYNC_TIMEOUT_EN
    assign rsp_ready = (state_q == DONE) && !sent_q;
`else
    assign rsp_ready = (state_q == DONE);
`endif

    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = rsp_ready;
        reg_rsp_o.rdata = rsp_ready ? rdata_q : '0;
        reg_rsp_o.error = rsp_ready ? err_q : 1'b0;
    end

    assign async_reg_req_req_o  = req_q;
    assign async_reg_rsp_ack_o  = ack_q;
    assign async_reg_req_data_o = data_q;
endmodule
